// File: rtl/add_out_pkg_hdl.sv
// Shared add_out types and default widths, common to the RTL, the monitor and the BFMs.
// An entry is {sum, tag}, with the sum in the upper bits.
package add_out_pkg_hdl;
    localparam int ADD_OUT_DATA_WIDTH = 8;
    localparam int ADD_OUT_TAG_WIDTH  = 4;
    localparam int ADD_OUT_DEPTH      = 4;

    typedef logic [ADD_OUT_DATA_WIDTH:0]  add_out_sum_t;
    typedef logic [ADD_OUT_TAG_WIDTH-1:0] add_out_tag_t;

    typedef struct packed {
        add_out_sum_t sum;
        add_out_tag_t tag;
    } add_out_entry_t;

    localparam int ADD_OUT_ENTRY_WIDTH = $bits(add_out_entry_t);
endpackage

// File: rtl/add_out_fifo.sv
// Register-based result FIFO. The head is read combinationally, so reads add no latency.
// Push is ignored when full and pop when empty; flush empties the FIFO and overrides both.
module add_out_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // The pointers carry one extra wrap bit, which tells full apart from empty.
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign count   = wr_q - rd_q;
    assign dout    = mem_q[rd_q[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            // Storage is cleared as well, so the head reads zero out of reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push) mem_q[wr_q[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/add_out_xmit.sv
// Transmit side of add_out: adds each operand pair, tags the sum with a wrapping sequence number, and queues the result.
// in_ready and out_valid decode only registered FIFO state, so there is no combinational in-to-out path.
module add_out_xmit
    import add_out_pkg_hdl::*;
#(
    parameter int DATA_WIDTH = ADD_OUT_DATA_WIDTH,
    parameter int DEPTH      = ADD_OUT_DEPTH,
    parameter int TAG_WIDTH  = ADD_OUT_TAG_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_a,
    input  logic [DATA_WIDTH-1:0]   in_b,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH:0]     out_sum,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int SW = DATA_WIDTH + 1;
    localparam int EW = SW + TAG_WIDTH;

    logic                 full, empty, push, pop;
    logic [SW-1:0]        sum;
    logic [EW-1:0]        din, dout;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;

    assign in_ready  = !full;
    assign out_valid = !empty;
    // A flush wins over a same-cycle accept, so the tag advances only on a real push.
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    assign sum     = SW'(in_a) + SW'(in_b);
    assign din     = {sum, tag_q};
    assign out_sum = dout[EW-1:TAG_WIDTH];
    assign out_tag = dout[TAG_WIDTH-1:0];

    always_comb begin
        tag_d = tag_q;
        if (push) tag_d = tag_q + TAG_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) tag_q <= '0;
        else     tag_q <= tag_d;
    end

    add_out_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );
endmodule

// File: tb/tb_add_out_xmit.sv
// Bench for add_out_xmit: directed vector table, streaming wrap sequence, then random traffic against a queue model.
module tb_add_out_xmit;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [7:0] in_a, in_b;
    logic [8:0] out_sum;
    logic [3:0] out_tag;
    logic [2:0] count;

    int passed = 0;
    int total  = 0;

    // Reference model: the queued results in order, plus the next tag to hand out.
    int q_sum[$];
    int q_tag[$];
    int m_tag = 0;

    typedef struct {
        logic       r, v;
        logic [7:0] a, b;
        logic       f, o;
        logic       e_rdy, e_vld;
        int         e_cnt;
        logic       hd;
        int         e_sum, e_tag;
    } vec_t;

    vec_t tbl[$];

    add_out_xmit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_tag   (out_tag),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic r, v, input int a, b, input logic f, o,
                                input logic rdy, vld, input int cnt, input logic hd,
                                input int s, t);
        vec_t x;
        x.r = r; x.v = v; x.a = 8'(a); x.b = 8'(b); x.f = f; x.o = o;
        x.e_rdy = rdy; x.e_vld = vld; x.e_cnt = cnt; x.hd = hd; x.e_sum = s; x.e_tag = t;
        return x;
    endfunction

    // One clock: check the state against the model, apply the inputs at the edge, then advance the model.
    task automatic drive(input logic r, v, input logic [7:0] a, b, input logic f, o);
        bit acc, pp;
        rst = r; in_valid = v; in_a = a; in_b = b; flush = f; out_ready = o;
        if (!r) begin
            chk("m_in_ready", int'(in_ready), int'(q_sum.size() < 4));
            chk("m_out_valid", int'(out_valid), int'(q_sum.size() > 0));
            chk("m_count", int'(count), q_sum.size());
            if (q_sum.size() > 0) begin
                chk("m_out_sum", int'(out_sum), q_sum[0]);
                chk("m_out_tag", int'(out_tag), q_tag[0]);
            end
        end
        @(posedge clk);
        if (r) begin
            q_sum.delete(); q_tag.delete(); m_tag = 0;
        end else if (f) begin
            q_sum.delete(); q_tag.delete();
        end else begin
            acc = v && (q_sum.size() < 4);
            pp  = o && (q_sum.size() > 0);
            if (pp) begin
                void'(q_sum.pop_front());
                void'(q_tag.pop_front());
            end
            if (acc) begin
                q_sum.push_back(int'(a) + int'(b));
                q_tag.push_back(m_tag);
                m_tag = (m_tag + 1) % 16;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;

        //              r  v  a    b    f  o   rdy vld cnt hd sum  tag
        tbl.push_back(mk(1, 0, 0,   0,   0, 0,  1,  0,  0,  1, 0,   0));
        tbl.push_back(mk(1, 0, 0,   0,   0, 0,  1,  0,  0,  1, 0,   0));
        tbl.push_back(mk(0, 1, 255, 1,   0, 1,  1,  1,  1,  1, 256, 0));
        tbl.push_back(mk(0, 0, 0,   0,   0, 1,  1,  0,  0,  0, 0,   0));
        tbl.push_back(mk(0, 1, 1,   1,   0, 0,  1,  1,  1,  1, 2,   1));
        tbl.push_back(mk(0, 1, 2,   2,   0, 0,  1,  1,  2,  1, 2,   1));
        // Reset held for three cycles mid-burst
        tbl.push_back(mk(1, 1, 3,   3,   0, 0,  1,  0,  0,  1, 0,   0));
        tbl.push_back(mk(1, 1, 3,   3,   0, 0,  1,  0,  0,  1, 0,   0));
        tbl.push_back(mk(1, 1, 3,   3,   0, 0,  1,  0,  0,  1, 0,   0));
        // Fill to four, then hold the fifth pair until the first pop
        tbl.push_back(mk(0, 1, 1,   1,   0, 0,  1,  1,  1,  1, 2,   0));
        tbl.push_back(mk(0, 1, 2,   2,   0, 0,  1,  1,  2,  1, 2,   0));
        tbl.push_back(mk(0, 1, 3,   3,   0, 0,  1,  1,  3,  1, 2,   0));
        tbl.push_back(mk(0, 1, 4,   4,   0, 0,  0,  1,  4,  1, 2,   0));
        tbl.push_back(mk(0, 1, 5,   5,   0, 0,  0,  1,  4,  1, 2,   0));
        tbl.push_back(mk(0, 1, 5,   5,   0, 1,  1,  1,  3,  1, 4,   1));
        tbl.push_back(mk(0, 1, 5,   5,   0, 0,  0,  1,  4,  1, 4,   1));
        tbl.push_back(mk(0, 0, 0,   0,   0, 1,  1,  1,  3,  1, 6,   2));
        tbl.push_back(mk(0, 0, 0,   0,   0, 1,  1,  1,  2,  1, 8,   3));
        tbl.push_back(mk(0, 0, 0,   0,   0, 1,  1,  1,  1,  1, 10,  4));
        tbl.push_back(mk(0, 0, 0,   0,   0, 1,  1,  0,  0,  0, 0,   0));
        // Simultaneous push and pop at count 2
        tbl.push_back(mk(0, 1, 10,  20,  0, 0,  1,  1,  1,  1, 30,  5));
        tbl.push_back(mk(0, 1, 7,   8,   0, 0,  1,  1,  2,  1, 30,  5));
        tbl.push_back(mk(0, 1, 100, 100, 0, 1,  1,  1,  2,  1, 15,  6));
        tbl.push_back(mk(0, 0, 0,   0,   0, 1,  1,  1,  1,  1, 200, 7));
        tbl.push_back(mk(0, 1, 1,   2,   0, 0,  1,  1,  2,  1, 200, 7));
        tbl.push_back(mk(0, 1, 3,   4,   0, 0,  1,  1,  3,  1, 200, 7));
        // Flush at count 3 with a live input: the input is dropped and the tag does not advance
        tbl.push_back(mk(0, 1, 9,   9,   1, 0,  1,  0,  0,  0, 0,   0));
        tbl.push_back(mk(0, 1, 5,   6,   0, 1,  1,  1,  1,  1, 11,  10));
        tbl.push_back(mk(0, 0, 0,   0,   0, 1,  1,  0,  0,  0, 0,   0));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].o);
            chk($sformatf("v%0d_in_ready", i), int'(in_ready), int'(tbl[i].e_rdy));
            chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_vld));
            chk($sformatf("v%0d_count", i), int'(count), tbl[i].e_cnt);
            if (tbl[i].hd) begin
                chk($sformatf("v%0d_out_sum", i), int'(out_sum), tbl[i].e_sum);
                chk($sformatf("v%0d_out_tag", i), int'(out_tag), tbl[i].e_tag);
            end
        end

        // Streaming for 20 cycles: one result per cycle, with tags wrapping 15 -> 0
        drive(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 8'(k), 8'(2 * k), 0, 1);
            chk("stream_count_le1", int'(count <= 3'd1), 1);
            chk("stream_valid", int'(out_valid), 1);
            chk("stream_tag", int'(out_tag), k % 16);
            chk("stream_sum", int'(out_sum), 3 * k);
        end

        // Random traffic with occasional flush and reset
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), 8'($urandom), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 2) != 0));
        end
        drive(0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
